dither_arbiter: RTL



---
 rtl/dither_pkg.sv | 21 ++
 rtl/dither_arbiter_lfsr_core.sv | 37 +++
 rtl/dither_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dither_pkg.sv
// Shared constants, FSM state type and the LFSR step function for the
// dither arbiter slice.
package dither_pkg;

  localparam int LFSR_W = 20;
  localparam int TAP_A  = 19;
  localparam int TAP_B  = 16;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED_C = 20'h00001;
  localparam logic [4:0] MAX_SHIFT = 5'd19;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } dither_state_e;

  // Fibonacci step for x^20 + x^17 + 1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_A] ^ q[TAP_B]};
  endfunction

endpackage

// File: rtl/dither_arbiter_lfsr_core.sv
// 20-bit LFSR register: load beats step, async active-low reset to SEED.
module lfsr_core
  import dither_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED_C
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              step_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] load_val_i,
  output logic [LFSR_W-1:0] q_o
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (step_i) begin
      q_d = lfsr_step(q_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/dither_arbiter.sv
// Shares one LFSR dither source among NUM_CH channels: seeding, warm-up,
// then round-robin grants that each consume exactly one LFSR draw.
// Handshake: req_i is a level sampled every edge; a grant is the registered
// one-hot gnt_o with dither_valid_o, one cycle after the sampling edge.
module dither_arbiter
  import dither_pkg::*;
#(
  parameter int                NUM_CH       = 4,
  parameter int                WARMUP       = 64,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = DEFAULT_SEED_C
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [LFSR_W-1:0]         seed_i,
  input  logic                      seed_load_i,
  input  logic [4:0]                shift_i,
  input  logic [NUM_CH-1:0]         req_i,
  output logic [NUM_CH-1:0]         gnt_o,
  output logic                      dither_valid_o,
  output logic [$clog2(NUM_CH)-1:0] dither_ch_o,
  output logic signed [LFSR_W-1:0]  dither_o,
  output logic                      ready_o,
  output dither_state_e             dbg_state_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam dither_state_e RESET_ST = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  dither_state_e            state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [CH_W-1:0]          ptr_q;
  logic [NUM_CH-1:0]        gnt_q;
  logic                     valid_q;
  logic [CH_W-1:0]          ch_q;
  logic signed [LFSR_W-1:0] dither_q;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] seed_d;
  logic              found;
  logic [CH_W-1:0]   win;
  logic [CH_W-1:0]   idx;
  logic [CH_W-1:0]   ptr_d;
  logic [4:0]        shift_sat;
  logic              grant_now;
  logic              lfsr_step_en;

  // Cyclic search starting at the pointer; first requester found wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + CH_W'(1);
    end
  end

  assign ptr_d        = (win == CH_W'(NUM_CH - 1)) ? '0 : win + CH_W'(1);
  assign shift_sat    = (shift_i > MAX_SHIFT) ? MAX_SHIFT : shift_i;
  assign seed_d       = (seed_i == '0) ? DEFAULT_SEED : seed_i;
  assign grant_now    = (state_q == ST_RUN) && found && !seed_load_i;
  assign lfsr_step_en = !seed_load_i && ((state_q == ST_WARMUP) || grant_now);

  lfsr_core #(
    .SEED(DEFAULT_SEED)
  ) u_lfsr (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .step_i    (lfsr_step_en),
    .load_i    (seed_load_i),
    .load_val_i(seed_d),
    .q_o       (lfsr_q)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RESET_ST;
      cnt_q    <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      ch_q     <= '0;
      dither_q <= '0;
    end else begin
      gnt_q   <= '0;
      valid_q <= 1'b0;
      if (seed_load_i) begin
        state_q <= RESET_ST;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_WARMUP: begin
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_RUN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_RUN: begin
            if (grant_now) begin
              gnt_q    <= {{(NUM_CH-1){1'b0}}, 1'b1} << win;
              valid_q  <= 1'b1;
              ch_q     <= win;
              dither_q <= $signed(lfsr_q) >>> shift_sat;
              ptr_q    <= ptr_d;
            end
          end
          default: state_q <= ST_WARMUP;
        endcase
      end
    end
  end

  assign gnt_o          = gnt_q;
  assign dither_valid_o = valid_q;
  assign dither_ch_o    = ch_q;
  assign dither_o       = dither_q;
  assign ready_o        = (state_q == ST_RUN);
  assign dbg_state_o    = state_q;

endmodule
